// File: rtl/rob_commit_buffer.sv
// rtl/rob_commit_buffer.sv - in-order reorder buffer with writeback capture, operand lookup and commit
// Optional ROB_WB_COMMIT_BYPASS_EN: a writeback to the head entry retires it on the same edge.
module rob_commit_buffer #(
    parameter int ROB_ADDR_WIDTH = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      alloc_en,
    input  logic                      alloc_has_dest,
    input  logic [REG_ADDR_WIDTH-1:0] alloc_dest,
    output logic                      alloc_ready,
    output logic [ROB_ADDR_WIDTH-1:0] alloc_id,
    input  logic                      wb_en,
    input  logic [ROB_ADDR_WIDTH-1:0] wb_id,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    input  logic                      read_en_1,
    input  logic [ROB_ADDR_WIDTH-1:0] read_id_1,
    input  logic                      read_en_2,
    input  logic [ROB_ADDR_WIDTH-1:0] read_id_2,
    output logic                      read_ready_1,
    output logic [DATA_WIDTH-1:0]     read_value_1,
    output logic                      read_ready_2,
    output logic [DATA_WIDTH-1:0]     read_value_2,
    output logic                      commit_en,
    output logic [REG_ADDR_WIDTH-1:0] commit_addr,
    output logic [DATA_WIDTH-1:0]     commit_data,
    output logic [ROB_ADDR_WIDTH-1:0] commit_id,
    output logic                      empty,
    output logic [ROB_ADDR_WIDTH:0]   count
);
    localparam int DEPTH = 1 << ROB_ADDR_WIDTH;
    localparam logic [ROB_ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ROB_ADDR_WIDTH{1'b0}}};

    logic [DEPTH-1:0]          r_valid;
    logic [DEPTH-1:0]          r_done;
    logic [DEPTH-1:0]          r_has_dest;
    logic [REG_ADDR_WIDTH-1:0] r_dest  [DEPTH];
    logic [DATA_WIDTH-1:0]     r_value [DEPTH];
    logic [ROB_ADDR_WIDTH:0]   r_head;
    logic [ROB_ADDR_WIDTH:0]   r_tail;

    logic [ROB_ADDR_WIDTH-1:0] w_head_idx;
    logic [ROB_ADDR_WIDTH-1:0] w_tail_idx;
    logic [ROB_ADDR_WIDTH:0]   w_count;
    logic                      w_full;
    logic                      w_alloc_fire;
    logic                      w_wb_hit;
    logic                      w_head_done;
    logic                      w_head_bypass;
    logic                      w_retire;
    logic [DATA_WIDTH-1:0]     w_retire_data;

    assign w_head_idx   = r_head[ROB_ADDR_WIDTH-1:0];
    assign w_tail_idx   = r_tail[ROB_ADDR_WIDTH-1:0];
    assign w_count      = r_tail - r_head;
    assign w_full       = (w_count == FULL_COUNT);
    assign alloc_ready  = rst & ~w_full & ~flush;
    assign alloc_id     = w_tail_idx;
    assign w_alloc_fire = alloc_en & alloc_ready;
    assign w_wb_hit     = wb_en & r_valid[wb_id];
    assign w_head_done  = r_valid[w_head_idx] & r_done[w_head_idx];
    assign count        = rst ? w_count : '0;
    assign empty        = (count == '0);

`ifdef ROB_WB_COMMIT_BYPASS_EN
    assign w_head_bypass = wb_en & (wb_id == w_head_idx) & r_valid[w_head_idx] & ~r_done[w_head_idx];
`else
    assign w_head_bypass = 1'b0;
`endif

    assign w_retire      = w_head_done | w_head_bypass;
    assign w_retire_data = w_head_done ? r_value[w_head_idx] : wb_data;

    // Lookup result packed as {ready, value}; a same-cycle writeback wins over stored state.
    function automatic logic [DATA_WIDTH:0] lookup(input logic en, input logic [ROB_ADDR_WIDTH-1:0] id);
        logic [DATA_WIDTH:0] res;
        res = '0;
        if (rst && en && r_valid[id]) begin
            if (wb_en && (wb_id == id)) begin
                res = {1'b1, wb_data};
            end else if (r_done[id]) begin
                res = {1'b1, r_value[id]};
            end
        end
        return res;
    endfunction

    always_comb begin
        {read_ready_1, read_value_1} = lookup(read_en_1, read_id_1);
    end

    always_comb begin
        {read_ready_2, read_value_2} = lookup(read_en_2, read_id_2);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid     <= '0;
            r_done      <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            commit_en   <= 1'b0;
            commit_addr <= '0;
            commit_data <= '0;
            commit_id   <= '0;
        end else if (flush) begin
            r_valid   <= '0;
            r_done    <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            commit_en <= 1'b0;
        end else begin
            if (w_wb_hit) begin
                r_done[wb_id]  <= 1'b1;
                r_value[wb_id] <= wb_data;
            end
            if (w_retire) begin
                r_valid[w_head_idx] <= 1'b0;
                r_head              <= r_head + 1'b1;
                commit_en           <= r_has_dest[w_head_idx];
                commit_addr         <= r_dest[w_head_idx];
                commit_data         <= w_retire_data;
                commit_id           <= w_head_idx;
            end else begin
                commit_en <= 1'b0;
            end
            // Tail slot is never valid when allocation is allowed, so no clash with retire/wb.
            if (w_alloc_fire) begin
                r_valid[w_tail_idx]    <= 1'b1;
                r_done[w_tail_idx]     <= 1'b0;
                r_has_dest[w_tail_idx] <= alloc_has_dest;
                r_dest[w_tail_idx]     <= alloc_dest;
                r_tail                 <= r_tail + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rob_commit_buffer.sv
// tb/tb_rob_commit_buffer.sv - directed self-checking bench for rob_commit_buffer
module tb_rob_commit_buffer;
    logic        clk = 1'b0;
    logic        rst, flush;
    logic        alloc_en, alloc_has_dest;
    logic [4:0]  alloc_dest;
    logic        alloc_ready;
    logic [3:0]  alloc_id;
    logic        wb_en;
    logic [3:0]  wb_id;
    logic [31:0] wb_data;
    logic        read_en_1, read_en_2;
    logic [3:0]  read_id_1, read_id_2;
    logic        read_ready_1, read_ready_2;
    logic [31:0] read_value_1, read_value_2;
    logic        commit_en;
    logic [4:0]  commit_addr;
    logic [31:0] commit_data;
    logic [3:0]  commit_id;
    logic        empty;
    logic [4:0]  count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rob_commit_buffer dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_en(alloc_en), .alloc_has_dest(alloc_has_dest), .alloc_dest(alloc_dest),
        .alloc_ready(alloc_ready), .alloc_id(alloc_id),
        .wb_en(wb_en), .wb_id(wb_id), .wb_data(wb_data),
        .read_en_1(read_en_1), .read_id_1(read_id_1), .read_en_2(read_en_2), .read_id_2(read_id_2),
        .read_ready_1(read_ready_1), .read_value_1(read_value_1),
        .read_ready_2(read_ready_2), .read_value_2(read_value_2),
        .commit_en(commit_en), .commit_addr(commit_addr), .commit_data(commit_data),
        .commit_id(commit_id), .empty(empty), .count(count)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input logic hd, input logic [4:0] dest);
        alloc_en = 1'b1; alloc_has_dest = hd; alloc_dest = dest;
        tick();
        alloc_en = 1'b0;
    endtask

    task automatic do_wb(input logic [3:0] id, input logic [31:0] data);
        wb_en = 1'b1; wb_id = id; wb_data = data;
        tick();
        wb_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0;
        alloc_en = 1'b0; alloc_has_dest = 1'b0; alloc_dest = '0;
        wb_en = 1'b0; wb_id = '0; wb_data = '0;
        read_en_1 = 1'b0; read_id_1 = '0; read_en_2 = 1'b0; read_id_2 = '0;
        tick(); tick();
        check("rst_alloc_ready", alloc_ready, 0);
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        check("rst_commit_en", commit_en, 0);
        rst = 1'b1;
        #1;
        check("post_rst_alloc_ready", alloc_ready, 1);

        // 1: three allocations
        alloc_en = 1'b1; alloc_has_dest = 1'b1; alloc_dest = 5'd1;
        #1 check("alloc_id0", alloc_id, 0);
        tick(); alloc_dest = 5'd2;
        check("alloc_id1", alloc_id, 1);
        tick(); alloc_dest = 5'd3;
        check("alloc_id2", alloc_id, 2);
        tick(); alloc_en = 1'b0;
        check("count3", count, 3);
        check("empty3", empty, 0);
        check("commit_idle", commit_en, 0);

        // 2: out-of-order completion, in-order commit
        do_wb(4'd2, 32'h33);
        read_en_2 = 1'b1; read_id_2 = 4'd2;
        #1 check("read2_done_ready", read_ready_2, 1);
        check("read2_done_value", read_value_2, 32'h33);
        read_en_2 = 1'b0;
        #1 check("read2_disabled", read_value_2, 0);
        do_wb(4'd1, 32'h22);
        check("no_commit_before_head", commit_en, 0);
        do_wb(4'd0, 32'h11);
        check("no_commit_at_wb_edge", commit_en, 0);
        tick();
        check("c0_en", commit_en, 1);
        check("c0_addr", commit_addr, 1);
        check("c0_data", commit_data, 32'h11);
        check("c0_id", commit_id, 0);
        tick();
        check("c1_addr", commit_addr, 2);
        check("c1_data", commit_data, 32'h22);
        check("c1_id", commit_id, 1);
        tick();
        check("c2_en", commit_en, 1);
        check("c2_data", commit_data, 32'h33);
        check("c2_id", commit_id, 2);
        tick();
        check("c_done_en", commit_en, 0);
        check("c_done_empty", empty, 1);

        // 3: fill, full behaviour, wrap
        flush = 1'b1; tick(); flush = 1'b0;
        for (int i = 0; i < 16; i++) do_alloc(1'b0, 5'(i));
        check("full_count", count, 16);
        check("full_ready", alloc_ready, 0);
        do_alloc(1'b1, 5'd9);
        check("full_ignored_count", count, 16);
        do_wb(4'd0, 32'h77);
        check("full_ready_commit_pending", alloc_ready, 0);
        do_alloc(1'b1, 5'd9);
        check("nodest_commit_en", commit_en, 0);
        check("nodest_commit_id", commit_id, 0);
        check("after_commit_count", count, 15);
        check("after_commit_ready", alloc_ready, 1);
        check("wrap_alloc_id", alloc_id, 0);
        do_alloc(1'b1, 5'd9);
        check("refill_count", count, 16);

        // 4: lookup bypass vs not ready
        read_en_1 = 1'b1; read_id_1 = 4'd5;
        wb_en = 1'b1; wb_id = 4'd5; wb_data = 32'hDEAD;
        #1 check("bypass_ready", read_ready_1, 1);
        check("bypass_value", read_value_1, 32'hDEAD);
        wb_en = 1'b0;
        #1 check("notdone_ready", read_ready_1, 0);
        check("notdone_value", read_value_1, 0);
        read_en_1 = 1'b0;

        // 5: flush with a completed head
        flush = 1'b1; tick(); flush = 1'b0;
        for (int i = 0; i < 4; i++) do_alloc(1'b1, 5'(4 + i));
        do_wb(4'd0, 32'hAA);
        flush = 1'b1;
        #1 check("flush_blocks_alloc", alloc_ready, 0);
        tick(); flush = 1'b0;
        check("flush_commit_en", commit_en, 0);
        check("flush_empty", empty, 1);
        check("flush_alloc_id", alloc_id, 0);
        do_wb(4'd2, 32'h99);
        read_en_1 = 1'b1; read_id_1 = 4'd2;
        #1 check("stale_wb_ready", read_ready_1, 0);
        check("stale_wb_count", count, 0);
        read_en_1 = 1'b0;

        // 6: writeback-to-commit latency
        do_alloc(1'b1, 5'd7);
        do_wb(4'd0, 32'h55);
`ifdef ROB_WB_COMMIT_BYPASS_EN
        check("lat_en", commit_en, 1);
`else
        check("lat_en_early", commit_en, 0);
        tick();
        check("lat_en", commit_en, 1);
`endif
        check("lat_addr", commit_addr, 7);
        check("lat_data", commit_data, 32'h55);

        // reset mid-operation clears everything
        do_alloc(1'b1, 5'd3);
        rst = 1'b0;
        tick();
        check("mid_rst_addr", commit_addr, 0);
        check("mid_rst_data", commit_data, 0);
        check("mid_rst_count", count, 0);
        rst = 1'b1;
        #1 check("mid_rst_alloc_id", alloc_id, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
